// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the 3-stage pipeline hazard controller:
// opcodes, forward-select encodings, FSM states and the scoreboard entry.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_X  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_e;

    localparam int SB_ENTRY_W = 7;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [4:0] rd;
    } sb_entry_t;

    // A load in X has no result yet, so only a non-load X entry may forward.
    function automatic logic [1:0] fwd_sel(input sb_entry_t x_e, input sb_entry_t w_e,
                                           input logic used, input logic [4:0] adr);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && adr != 5'd0) begin
            if (x_e.valid && !x_e.is_load && x_e.rd == adr) begin
                sel = FWD_X;
            end else if (w_e.valid && w_e.rd == adr) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_classify.sv
// Combinational opcode classification: which registers an instruction
// reads, whether it writes a non-zero rd, and whether it is a load.
module hazard_classify
    import hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    output logic       writes_rd,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       is_load
);

    logic writes_any;

    always_comb begin
        writes_any = 1'b0;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        is_load    = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                writes_any = 1'b1;
                uses_rs1   = 1'b0;
            end
            OP_JALR, OP_ARI_ITYPE: writes_any = 1'b1;
            OP_LOAD: begin
                writes_any = 1'b1;
                is_load    = 1'b1;
            end
            OP_ARI_RTYPE: begin
                writes_any = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_BRANCH, OP_STORE: uses_rs2 = 1'b1;
            default: ;
        endcase
        writes_rd = writes_any && (rd != 5'd0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the D/X/W pipeline: scoreboard of X and W
// destinations, operand forwarding, load-use stall, redirect kill, memory hold.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [6:0]       d_opcode,
    input  logic [4:0]       d_rd,
    input  logic [4:0]       d_adr1,
    input  logic [4:0]       d_adr2,
    input  logic             x_taken,
    input  logic             mem_stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_d,
    output logic             bubble_x,
    output logic             kill_d,
    output logic             hold_xw,
    output logic [CNT_W-1:0] stall_cnt
);

    logic      writes_rd;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      is_load;
    logic      lu;
    sb_entry_t x_e;
    sb_entry_t w_e;
    state_e    state;

    hazard_classify u_classify (
        .opcode    (d_opcode),
        .rd        (d_rd),
        .writes_rd (writes_rd),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .is_load   (is_load)
    );

    assign lu = d_valid && x_e.valid && x_e.is_load &&
                ((uses_rs1 && d_adr1 != 5'd0 && x_e.rd == d_adr1) ||
                 (uses_rs2 && d_adr2 != 5'd0 && x_e.rd == d_adr2));

    always_comb begin
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        stall_d  = 1'b0;
        bubble_x = 1'b0;
        kill_d   = 1'b0;
        hold_xw  = 1'b0;
        if (!rst) begin
            fwd_a = fwd_sel(x_e, w_e, uses_rs1, d_adr1);
            fwd_b = fwd_sel(x_e, w_e, uses_rs2, d_adr2);
            if (mem_stall) begin
                hold_xw = 1'b1;
                stall_d = 1'b1;
            end else if (x_taken) begin
                kill_d   = 1'b1;
                bubble_x = 1'b1;
            end else if (lu) begin
                stall_d  = 1'b1;
                bubble_x = 1'b1;
            end
        end
    end

    // LU_BUBBLE needs no special outputs: X_e is invalid there, so lu cannot
    // fire again and the load in W is picked up by the W forward path.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_e       <= '0;
            w_e       <= '0;
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            if (stall_d && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (mem_stall) begin
                state <= MEM_WAIT;
            end else if (x_taken) begin
                x_e   <= '0;
                w_e   <= x_e;
                state <= RUN;
            end else if (lu) begin
                x_e   <= '0;
                w_e   <= x_e;
                state <= LU_BUBBLE;
            end else begin
                x_e.valid   <= d_valid && writes_rd;
                x_e.is_load <= is_load;
                x_e.rd      <= d_rd;
                w_e         <= x_e;
                state       <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: an instruction-level pipeline model
// compared every cycle, plus directed sequences with literal expectations.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic [6:0]  d_opcode;
    logic [4:0]  d_rd;
    logic [4:0]  d_adr1;
    logic [4:0]  d_adr2;
    logic        x_taken;
    logic        mem_stall;
    logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic        stall_d, bubble_x, kill_d, hold_xw;
    logic        stall_d_s, bubble_x_s, kill_d_s, hold_xw_s;
    logic [31:0] stall_cnt;
    logic [2:0]  stall_cnt_s;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_opcode(d_opcode), .d_rd(d_rd),
        .d_adr1(d_adr1), .d_adr2(d_adr2), .x_taken(x_taken), .mem_stall(mem_stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_d(stall_d), .bubble_x(bubble_x),
        .kill_d(kill_d), .hold_xw(hold_xw), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_opcode(d_opcode), .d_rd(d_rd),
        .d_adr1(d_adr1), .d_adr2(d_adr2), .x_taken(x_taken), .mem_stall(mem_stall),
        .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_d(stall_d_s), .bubble_x(bubble_x_s),
        .kill_d(kill_d_s), .hold_xw(hold_xw_s), .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: instructions in flight ----------------
    typedef struct {
        bit       v;
        bit       ld;
        bit [4:0] rd;
    } instr_t;

    instr_t in_x, in_w;
    int     m_cnt = 0;

    function automatic bit m_reads1(logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction
    function automatic bit m_reads2(logic [6:0] op);
        return op inside {OP_BRANCH, OP_STORE, OP_ARI_RTYPE};
    endfunction
    function automatic bit m_writes(logic [6:0] op, logic [4:0] rd);
        return (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
                           OP_ARI_RTYPE, OP_ARI_ITYPE}) && rd != 0;
    endfunction

    function automatic logic [1:0] m_src(bit used, logic [4:0] adr);
        if (!used || adr == 0) return 2'd0;
        if (in_x.v && !in_x.ld && in_x.rd == adr) return 2'd1;
        if (in_w.v && in_w.rd == adr) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_load_use();
        bit h1, h2;
        h1 = m_reads1(d_opcode) && d_adr1 != 0 && in_x.rd == d_adr1;
        h2 = m_reads2(d_opcode) && d_adr2 != 0 && in_x.rd == d_adr2;
        return d_valid && in_x.v && in_x.ld && (h1 || h2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            in_x  = '{0, 0, 0};
            in_w  = '{0, 0, 0};
            m_cnt = 0;
        end else if (mem_stall) begin
            m_cnt++;
        end else if (x_taken) begin
            in_w = in_x;
            in_x = '{0, 0, 0};
        end else if (m_load_use()) begin
            m_cnt++;
            in_w = in_x;
            in_x = '{0, 0, 0};
        end else begin
            in_w = in_x;
            in_x = '{d_valid && m_writes(d_opcode, d_rd), d_opcode == OP_LOAD, d_rd};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [1:0] ea, eb;
            bit es, eb_x, ek, eh;
            ea = rst ? 2'd0 : m_src(m_reads1(d_opcode), d_adr1);
            eb = rst ? 2'd0 : m_src(m_reads2(d_opcode), d_adr2);
            es = !rst && (mem_stall || (!x_taken && m_load_use()));
            eh = !rst && mem_stall;
            ek = !rst && !mem_stall && x_taken;
            eb_x = !rst && !mem_stall && (x_taken || m_load_use());
            check("m_fwd_a", 32'(fwd_a), 32'(ea));
            check("m_fwd_b", 32'(fwd_b), 32'(eb));
            check("m_stall_d", 32'(stall_d), 32'(es));
            check("m_bubble_x", 32'(bubble_x), 32'(eb_x));
            check("m_kill_d", 32'(kill_d), 32'(ek));
            check("m_hold_xw", 32'(hold_xw), 32'(eh));
            check("m_stall_cnt", stall_cnt, 32'(m_cnt));
            check("m_stall_cnt_sat", 32'(stall_cnt_s), 32'((m_cnt > 7) ? 7 : m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ins(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2);
        d_valid   = 1'b1;
        d_opcode  = op;
        d_rd      = rd;
        d_adr1    = a1;
        d_adr2    = a2;
        x_taken   = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic nop_in();
        d_valid   = 1'b0;
        d_opcode  = 7'd0;
        d_rd      = 5'd0;
        d_adr1    = 5'd0;
        d_adr2    = 5'd0;
        x_taken   = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        nop_in();
        tick();
        tick();
        cmp_en = 1'b1;
        #2;
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_state", 32'(dut.state), 32'(RUN));
        rst = 1'b0;
        tick();

        // back-to-back ALU dependency forwards from X
        ins(OP_ARI_ITYPE, 5, 1, 0); tick();
        ins(OP_ARI_RTYPE, 6, 5, 5); #2;
        check("b2b_fwd_a", 32'(fwd_a), 32'd1);
        check("b2b_fwd_b", 32'(fwd_b), 32'd1);
        check("b2b_stall", 32'(stall_d), 32'd0);
        tick();

        // one independent instruction between: forward from W
        ins(OP_ARI_ITYPE, 5, 1, 0); tick();
        ins(OP_ARI_ITYPE, 10, 0, 0); tick();
        ins(OP_ARI_RTYPE, 6, 5, 5); #2;
        check("gap_fwd_a", 32'(fwd_a), 32'd2);
        check("gap_fwd_b", 32'(fwd_b), 32'd2);
        tick();

        // load-use: one bubble, then forward from W
        ins(OP_LOAD, 7, 2, 0); tick();
        ins(OP_ARI_RTYPE, 8, 7, 0); #2;
        check("lu_stall", 32'(stall_d), 32'd1);
        check("lu_bubble", 32'(bubble_x), 32'd1);
        tick(); #2;
        check("lub_state", 32'(dut.state), 32'(LU_BUBBLE));
        check("lub_fwd_a", 32'(fwd_a), 32'd2);
        check("lub_stall", 32'(stall_d), 32'd0);
        check("lub_cnt", stall_cnt, 32'd1);
        tick();
        nop_in(); #2;
        check("lu_run_state", 32'(dut.state), 32'(RUN));
        tick();

        // load-use coincident with a taken branch: kill wins, no stall
        ins(OP_LOAD, 12, 2, 0); tick();
        ins(OP_ARI_RTYPE, 13, 12, 0);
        x_taken = 1'b1; #2;
        check("tk_kill", 32'(kill_d), 32'd1);
        check("tk_bubble", 32'(bubble_x), 32'd1);
        check("tk_stall", 32'(stall_d), 32'd0);
        check("tk_cnt", stall_cnt, 32'd1);
        tick();
        ins(OP_ARI_RTYPE, 14, 13, 13); #2;
        check("tk_x_invalid", 32'(dut.x_e.valid), 32'd0);
        check("tk_fwd_a", 32'(fwd_a), 32'd0);
        tick();

        // memory wait for 3 cycles with a dependent op in D
        ins(OP_ARI_ITYPE, 15, 1, 0); tick();
        ins(OP_ARI_RTYPE, 16, 15, 15);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("ms_hold", 32'(hold_xw), 32'd1);
            check("ms_stall", 32'(stall_d), 32'd1);
            check("ms_fwd_a", 32'(fwd_a), 32'd1);
            if (i > 0) check("ms_state", 32'(dut.state), 32'(MEM_WAIT));
            tick();
        end
        mem_stall = 1'b0; #2;
        check("ms_rel_stall", 32'(stall_d), 32'd0);
        check("ms_rel_fwd", 32'(fwd_a), 32'd1);
        check("ms_cnt", stall_cnt, 32'd4);
        tick();
        ins(OP_ARI_RTYPE, 17, 16, 0); #2;
        check("ms_adv_fwd", 32'(fwd_a), 32'd1);
        check("ms_run_state", 32'(dut.state), 32'(RUN));
        tick();

        // x0 never forwards or stalls; LUI feeds a branch
        ins(OP_ARI_ITYPE, 0, 1, 0); tick();
        ins(OP_ARI_RTYPE, 17, 0, 0); #2;
        check("x0_fwd_a", 32'(fwd_a), 32'd0);
        check("x0_stall", 32'(stall_d), 32'd0);
        tick();
        ins(OP_LOAD, 0, 2, 0); tick();
        ins(OP_ARI_RTYPE, 18, 0, 0); #2;
        check("ldx0_stall", 32'(stall_d), 32'd0);
        tick();
        ins(OP_LUI, 9, 0, 0); tick();
        ins(OP_BRANCH, 0, 9, 0); #2;
        check("lui_br_fwd_a", 32'(fwd_a), 32'd1);
        tick();

        // reset during MEM_WAIT
        ins(OP_LOAD, 20, 2, 0); tick();
        ins(OP_ARI_RTYPE, 21, 20, 20);
        mem_stall = 1'b1;
        tick(); #2;
        check("rmw_state", 32'(dut.state), 32'(MEM_WAIT));
        rst = 1'b1; #1;
        check("rmw_rst_stall", 32'(stall_d), 32'd0);
        check("rmw_rst_hold", 32'(hold_xw), 32'd0);
        tick();
        rst = 1'b0;
        ins(OP_ARI_RTYPE, 21, 20, 20); #2;
        check("rmw_fwd_a", 32'(fwd_a), 32'd0);
        check("rmw_stall", 32'(stall_d), 32'd0);
        check("rmw_cnt", stall_cnt, 32'd0);
        check("rmw_state_run", 32'(dut.state), 32'(RUN));
        tick();

        // counter saturation on the narrow instance
        nop_in();
        mem_stall = 1'b1;
        repeat (10) tick();
        mem_stall = 1'b0; #2;
        check("sat_cnt_wide", stall_cnt, 32'd10);
        check("sat_cnt_narrow", 32'(stall_cnt_s), 32'd7);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
